reg_read: RTL
=============

REG_READ -- requirements
Module: reg_read

Interface
REQ-001 SHALL have port i_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port i_reset, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have ports decode_pc (32), decode_op (6), decode_altop (8), decode_rd/decode_rs/decode_rt (4 each), decode_imm32 (32), all inputs: registered decode-stage outputs; an all-zero bundle is a bubble.
REQ-004 SHALL have outputs rr_stall and rr_flush (1 each), driven to decode.
REQ-005 SHALL have inputs exec_stall and exec_flush (1 each), driven by execute.
REQ-006 SHALL have inputs wb_en (1), wb_rd (4) and wb_data (32): the writeback port.
REQ-007 SHALL have registered outputs rr_pc (32), rr_op (6), rr_altop (8), rr_rd (4), rr_imm32 (32), rr_rs_val (32), rr_rt_val (32) and rr_valid (1).

Function
REQ-008 Register file SHALL be 16x32; wb_en with wb_rd!=0 writes wb_data at the clock edge; register 0 is never written and reads as 0.
REQ-009 Reads SHALL bypass writeback: wb_en && wb_rd==decode_rs (rs!=0) selects wb_data that cycle; same for rt.
REQ-010 Scoreboard SHALL be a 16-bit pending vector; bit 0 is hardwired to 0.
REQ-011 Hazard SHALL be asserted when pending[rs] or pending[rt] or pending[rd] is set (index 0 excluded) and the same-cycle writeback does not clear that bit (REQ-009).
REQ-012 Issue SHALL occur when there is no hazard, no exec_stall and no exec_flush: output registers load the decode bundle plus read values, rr_valid<=1, and pending[rd]<=1 if rd!=0.
REQ-013 On a hazard without exec_stall, the stage SHALL load a bubble (all outputs 0, rr_valid 0) and assert rr_stall.
REQ-014 On exec_stall, output registers SHALL hold and rr_stall SHALL be 1.
REQ-015 rr_stall SHALL be combinational: exec_stall || hazard, forced to 0 during exec_flush.
REQ-016 On exec_flush, rr_flush SHALL be 1 the same cycle, output registers SHALL load a bubble next edge, and pending[rr_rd] SHALL clear if rr_valid and rr_rd!=0; flush overrides stall and hazard.
REQ-017 A writeback SHALL clear pending[wb_rd] at the edge; a same-edge issue setting the same bit SHALL win.
REQ-018 Latency SHALL be 1 cycle from decode bundle to rr_* outputs; throughput 1 per cycle absent hazards.
REQ-019 WAW stall (REQ-011) SHALL guarantee at most one outstanding writer per register.

Reset
REQ-020 While i_reset is low, every rr_* output register, register-file entry and pending bit SHALL be 0, asynchronously.
REQ-021 Reset asserted mid-stall SHALL drop the pending state; the first post-reset cycle SHALL see no hazard.

Structure
REQ-022 Opcode constants, NUM_REGS=16 and REG_W=4 SHALL live in the shared package cs3220_pkg.
REQ-023 The register file SHALL be a sub-module regfile (2 read ports, 1 write port, write-through bypass); scoreboard and pipeline registers stay in reg_read.

Verification
REQ-024 Reset then wb_en=1, wb_rd=3, wb_data=0xDEADBEEF; next cycle decode rs=3 -> rr_rs_val=0xDEADBEEF, rr_valid=1 after one edge.
REQ-025 Issue ADD rd=5; next cycle decode rs=5 -> rr_stall=1 and a bubble is loaded each cycle until wb_rd=5 (wb_data=0x12) -> same cycle issues with rr_rs_val=0x12.
REQ-026 Issue rd=7, then exec_flush=1 while rr_rd=7 -> rr_flush=1, outputs 0 next edge, pending[7]=0; a following reader of r7 does not stall.
REQ-027 exec_stall=1 for 3 cycles with rr_pc=0x40 -> rr_pc holds 0x40, rr_stall=1 each cycle, decode bundle not consumed.
REQ-028 wb_rd=4 clears while new instruction rd=4 issues the same edge -> pending[4]=1 afterward.
REQ-029 Write attempt with wb_rd=0, wb_data=0xFFFFFFFF; read rs=0 -> rr_rs_val=0, no stall.

Source files
------------

// File: rtl/cs3220_pkg.sv
// Shared CS3220 pipeline definitions: register-file geometry, opcode constants
// and the register-index helper used by the scoreboard.
package cs3220_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_W    = 4;
    localparam int DATA_W   = 32;

    localparam logic [5:0] OP_ALUR = 6'h01;
    localparam logic [5:0] OP_ALUI = 6'h02;
    localparam logic [5:0] OP_LW   = 6'h03;
    localparam logic [5:0] OP_SW   = 6'h04;
    localparam logic [5:0] OP_BEQ  = 6'h05;
    localparam logic [5:0] OP_JAL  = 6'h06;

    localparam logic [7:0] ALT_ADD = 8'h01;
    localparam logic [7:0] ALT_SUB = 8'h02;
    localparam logic [7:0] ALT_AND = 8'h03;
    localparam logic [7:0] ALT_OR  = 8'h04;

    // One-hot select of a register; r0 maps to an empty mask since it never has a writer.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_W-1:0] idx);
        reg_mask = '0;
        if (idx != '0)
            reg_mask[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/reg_read_if.sv
// Decode/execute/writeback bundle around the register-read stage.
// master drives decode, execute control and writeback; slave is the stage itself.
interface reg_read_if;
    import cs3220_pkg::*;

    logic [31:0]      decode_pc;
    logic [5:0]       decode_op;
    logic [7:0]       decode_altop;
    logic [REG_W-1:0] decode_rd;
    logic [REG_W-1:0] decode_rs;
    logic [REG_W-1:0] decode_rt;
    logic [31:0]      decode_imm32;

    logic             rr_stall;
    logic             rr_flush;
    logic             exec_stall;
    logic             exec_flush;

    logic             wb_en;
    logic [REG_W-1:0] wb_rd;
    logic [31:0]      wb_data;

    logic [31:0]      rr_pc;
    logic [5:0]       rr_op;
    logic [7:0]       rr_altop;
    logic [REG_W-1:0] rr_rd;
    logic [31:0]      rr_imm32;
    logic [31:0]      rr_rs_val;
    logic [31:0]      rr_rt_val;
    logic             rr_valid;

    modport master (
        output decode_pc, decode_op, decode_altop, decode_rd, decode_rs, decode_rt, decode_imm32,
        output exec_stall, exec_flush, wb_en, wb_rd, wb_data,
        input  rr_stall, rr_flush,
        input  rr_pc, rr_op, rr_altop, rr_rd, rr_imm32, rr_rs_val, rr_rt_val, rr_valid
    );

    modport slave (
        input  decode_pc, decode_op, decode_altop, decode_rd, decode_rs, decode_rt, decode_imm32,
        input  exec_stall, exec_flush, wb_en, wb_rd, wb_data,
        output rr_stall, rr_flush,
        output rr_pc, rr_op, rr_altop, rr_rd, rr_imm32, rr_rs_val, rr_rt_val, rr_valid
    );

endinterface

// File: rtl/reg_read_regfile.sv
// 16x32 register file, two read ports and one write port.
// A write to the register being read is forwarded in the same cycle; r0 is constant zero.
module regfile
    import cs3220_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_we,
    input  logic [REG_W-1:0] i_waddr,
    input  logic [31:0]      i_wdata,
    input  logic [REG_W-1:0] i_raddr0,
    input  logic [REG_W-1:0] i_raddr1,
    output logic [31:0]      o_rdata0,
    output logic [31:0]      o_rdata1
);

    logic [31:0] r_regs [NUM_REGS];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else if (i_we && i_waddr != '0) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata0 = r_regs[i_raddr0];
        if (i_raddr0 == '0)
            o_rdata0 = '0;
        else if (i_we && i_waddr == i_raddr0)
            o_rdata0 = i_wdata;
    end

    always_comb begin
        o_rdata1 = r_regs[i_raddr1];
        if (i_raddr1 == '0)
            o_rdata1 = '0;
        else if (i_we && i_waddr == i_raddr1)
            o_rdata1 = i_wdata;
    end

endmodule

// File: rtl/reg_read.sv
// Register-read pipeline stage: operand fetch with writeback bypass, a pending-writer
// scoreboard for RAW/WAW hazards, and the decode-to-execute pipeline registers.
module reg_read
    import cs3220_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    reg_read_if.slave   bus
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_wbClear;
    logic [NUM_REGS-1:0] w_live;
    logic [NUM_REGS-1:0] w_pendingNext;
    logic [31:0]         w_rsVal;
    logic [31:0]         w_rtVal;
    logic                w_hazard;
    logic                w_issue;
    logic                w_decodeValid;

    logic [31:0]      r_pc;
    logic [5:0]       r_op;
    logic [7:0]       r_altop;
    logic [REG_W-1:0] r_rd;
    logic [31:0]      r_imm32;
    logic [31:0]      r_rsVal;
    logic [31:0]      r_rtVal;
    logic             r_valid;

    regfile u_regfile (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_we     (bus.wb_en),
        .i_waddr  (bus.wb_rd),
        .i_wdata  (bus.wb_data),
        .i_raddr0 (bus.decode_rs),
        .i_raddr1 (bus.decode_rt),
        .o_rdata0 (w_rsVal),
        .o_rdata1 (w_rtVal)
    );

    // A writer retiring this cycle no longer blocks, so its bit is masked before the hazard check.
    assign w_wbClear = bus.wb_en ? reg_mask(bus.wb_rd) : '0;
    assign w_live    = r_pending & ~w_wbClear;
    assign w_hazard  = w_live[bus.decode_rs] || w_live[bus.decode_rt] || w_live[bus.decode_rd];
    assign w_issue   = !w_hazard && !bus.exec_stall && !bus.exec_flush;
    assign w_decodeValid = |{bus.decode_pc, bus.decode_op, bus.decode_altop, bus.decode_rd,
                             bus.decode_rs, bus.decode_rt, bus.decode_imm32};

    assign bus.rr_stall = !bus.exec_flush && (bus.exec_stall || w_hazard);
    assign bus.rr_flush = bus.exec_flush;

    // Set-after-clear ordering lets a same-edge issue win over a retiring writer.
    always_comb begin
        w_pendingNext = w_live;
        if (bus.exec_flush && r_valid)
            w_pendingNext = w_pendingNext & ~reg_mask(r_rd);
        if (w_issue)
            w_pendingNext = w_pendingNext | reg_mask(bus.decode_rd);
        w_pendingNext[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            r_pending <= '0;
        else
            r_pending <= w_pendingNext;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset || 1'b0) begin
            r_pc    <= '0;
            r_op    <= '0;
            r_altop <= '0;
            r_rd    <= '0;
            r_imm32 <= '0;
            r_rsVal <= '0;
            r_rtVal <= '0;
            r_valid <= 1'b0;
        end else if (bus.exec_flush || (!bus.exec_stall && w_hazard)) begin
            r_pc    <= '0;
            r_op    <= '0;
            r_altop <= '0;
            r_rd    <= '0;
            r_imm32 <= '0;
            r_rsVal <= '0;
            r_rtVal <= '0;
            r_valid <= 1'b0;
        end else if (!bus.exec_stall) begin
            r_pc    <= bus.decode_pc;
            r_op    <= bus.decode_op;
            r_altop <= bus.decode_altop;
            r_rd    <= bus.decode_rd;
            r_imm32 <= bus.decode_imm32;
            r_rsVal <= w_rsVal;
            r_rtVal <= w_rtVal;
            r_valid <= w_decodeValid;
        end
    end

    assign bus.rr_pc     = r_pc;
    assign bus.rr_op     = r_op;
    assign bus.rr_altop  = r_altop;
    assign bus.rr_rd     = r_rd;
    assign bus.rr_imm32  = r_imm32;
    assign bus.rr_rs_val = r_rsVal;
    assign bus.rr_rt_val = r_rtVal;
    assign bus.rr_valid  = r_valid;

endmodule
